// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32/int32 constants and operand classes for the FPU
package fpu_pkg;
  localparam int BIAS = 127;
  localparam int EXP_W = 8;
  localparam int FRA_W = 23;
  localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN = 32'h80000000;
  typedef enum logic [1:0] {ZERO, NORMAL, SATP, SATN} cls_t;
endpackage

// File: rtl/ftoi_shift.sv
// ftoi_shift: bidirectional barrel shift of a 24-bit mantissa to an integer magnitude
module ftoi_shift (
  input  logic [23:0] man,
  input  logic [4:0]  sh,
  output logic [31:0] mag
);
  logic [31:0] ext;
  assign ext = {8'd0, man};
  assign mag = sh >= 5'd23 ? ext << (sh - 5'd23) : ext >> (5'd23 - sh);
endmodule

// File: rtl/ftoi.sv
// ftoi: two-stage elastic binary32 to int32 converter, truncating and saturating
module ftoi
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf
);
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [4:0]       s1_sh_q, s1_sh_d;
  logic [FRA_W:0]   s1_man_q, s1_man_d;
  cls_t             s1_cls_q, s1_cls_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             s1_adv, s2_adv, ld1, ld2;
  logic [EXP_W-1:0] exp_w;
  logic [FRA_W-1:0] fra;
  logic [31:0]      mag;
  cls_t             cls;
  assign s2_adv    = ~s2_valid_q | out_ready;
  assign s1_adv    = ~s1_valid_q | s2_adv;
  assign in_ready  = s1_adv;
  assign ld1       = s1_adv & in_valid;
  assign ld2       = s2_adv & s1_valid_q;
  assign exp_w     = op[30:23];
  assign fra       = op[22:0];
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  // classify the incoming operand; -2^31 is the only exp>=158 value that fits
  always_comb begin
    cls = exp_w <= 8'd126 ? ZERO :
          exp_w == 8'hFF ? ((|fra || !op[31]) ? SATP : SATN) :
          (exp_w >= 8'd158 && op != 32'hCF000000) ? (op[31] ? SATN : SATP) :
          NORMAL;
  end
  // S1 decode: capture sign, unbiased shift, mantissa and class on input transfers
  always_comb begin
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_sign_d  = ld1 ? op[31] : s1_sign_q;
    s1_sh_d    = ld1 ? 5'(exp_w - 8'(BIAS)) : s1_sh_q;
    s1_man_d   = ld1 ? {1'b1, fra} : s1_man_q;
    s1_cls_d   = ld1 ? cls : s1_cls_q;
  end
  ftoi_shift u_shift (
    .man(s1_man_q),
    .sh (s1_sh_q),
    .mag(mag)
  );
  // S2 convert: pick saturated, zero or signed shifted magnitude
  always_comb begin
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    result_d   = !ld2 ? result_q :
                 s1_cls_q == ZERO ? 32'd0 :
                 s1_cls_q == SATP ? INT_MAX :
                 s1_cls_q == SATN ? INT_MIN :
                 s1_sign_q ? -mag : mag;
    ovf_d      = ld2 ? (s1_cls_q == SATP || s1_cls_q == SATN) : ovf_q;
  end
  // pipeline registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sh_q    <= '0;
      s1_man_q   <= '0;
      s1_cls_q   <= ZERO;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_sh_q    <= s1_sh_d;
      s1_man_q   <= s1_man_d;
      s1_cls_q   <= s1_cls_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_ftoi.sv
// tb_ftoi: scoreboard bench for ftoi against a real-arithmetic conversion model
module tb_ftoi;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] op = '0;
  logic        in_ready, out_valid, ovf;
  logic [31:0] result;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  ftoi dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf)
  );

  function automatic logic [32:0] model(input logic [31:0] v);
    int  e;
    real x;
    e = int'(v[30:23]);
    if (e == 255) return (v[22:0] != 0 || !v[31]) ? {1'b1, 32'h7FFFFFFF} : {1'b1, 32'h80000000};
    if (e == 0) x = real'(v[22:0]) * 2.0 ** (-149);
    else x = (real'(v[22:0]) + 8388608.0) * 2.0 ** (e - 150);
    if (v[31]) x = -x;
    if (x >= 2147483648.0) return {1'b1, 32'h7FFFFFFF};
    if (x < -2147483648.0) return {1'b1, 32'h80000000};
    return {1'b0, 32'($rtoi(x))};
  endfunction

  function automatic logic [31:0] rand_int_float();
    logic [7:0]  e;
    logic [22:0] f;
    int          sh;
    e  = 8'($urandom_range(158, 127));
    sh = int'(e) - 127;
    f  = 23'($urandom);
    if (sh < 23) f = f & ~23'((1 << (23 - sh)) - 1);
    return {1'($urandom), e, f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // monitor: pop the oldest expectation whenever a result is handed off
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h, required none", result);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e[31:0]);
        check("ovf", 32'(ovf), 32'(e[32]));
      end
    end
  end

  task automatic send(input logic [31:0] v);
    int t = 0;
    op = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, required 1");
    end else exp_q.push_back(model(v));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      t++;
      @(negedge clk);
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_lat(input logic [31:0] v);
    send(v);
    @(negedge clk);
    check("latency_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_due", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] dir[12];
    int          cnt;
    dir = '{32'h3F7FFFFF, 32'hBFC00000, 32'h80000000, 32'h00000001, 32'h4F000000, 32'hCF000000,
            32'hCF000001, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'hBF000000, 32'h4EFFFFFF};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    send_lat(32'h3F800000);
    send_lat(32'hC0400000);
    send_lat(32'h4B800001);
    foreach (dir[i]) send(dir[i]);
    drain();
    repeat (60) send($urandom);
    drain();

    cnt = 0;
    fork
      repeat (100) send(rand_int_float());
      begin
        repeat (2) @(posedge clk);
        repeat (100) begin
          @(negedge clk);
          cnt += int'(out_valid);
        end
      end
    join
    check("back_to_back", 32'(cnt), 32'd100);
    drain();

    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000);
        send(32'h40000000);
        send(32'h40400000);
        send(32'h40800000);
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
          t++;
          @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_result", result, 32'd1);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(32'h40A00000);
    send(32'h40C00000);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(32'hC2F60000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
